inst_fetch_queue: RTL and testbench

Parametrised successor to the single-slot instruction fetch unit. It prefetches instructions from the I-cache into a DEPTH-entry FIFO, decoupling cache latency from issue, and drains the FIFO to the issue stage one instruction per cycle when issue is not stalled. The fetch FSM talks to the I-cache and the issue-side queue feeds decode/issue. Both are flushed on a jump redirect from the ROB.

---
 rtl/inst_fetch_queue_pkg.sv | 21 ++
 rtl/inst_fetch_queue_fifo.sv | 51 +++++
 rtl/inst_fetch_queue.sv | 147 ++++++++++++++
 tb/tb_inst_fetch_queue.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_queue_pkg.sv
// Shared constants, fetch FSM encoding and fetch-entry layout for inst_fetch_queue.
// An entry is packed as {pred, pc, inst}: inst in [XLEN-1:0], pc in [2*XLEN-1:XLEN], pred at bit 2*XLEN.
package inst_fetch_queue_pkg;

  localparam logic HIGH  = 1'b1;
  localparam logic LOW   = 1'b0;
  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam logic [6:0] OPCODE_JAL = 7'b1101111;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } fetch_state_t;

  function automatic int entry_width(input int xlen);
    return 2 * xlen + 1;
  endfunction

endpackage

// File: rtl/inst_fetch_queue_fifo.sv
// Circular buffer of DEPTH entries with push, pop, flush and occupancy count.
// Latency: a push is visible at the head on the next cycle; the caller must never push when full or pop when empty.
module fetch_queue_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/inst_fetch_queue.sv
// Prefetching instruction fetch unit: I-cache requests feed a QUEUE_DEPTH FIFO drained one instruction per cycle to issue.
// Latency: hit pushed at its edge, issued one edge later; issue_stall blocks pops only, full queue blocks fetch; IF_JAL_PREDICT_EN enables JAL redirect.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              QUEUE_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             rdy,
  output logic                             pc_send_enable,
  output logic [XLEN-1:0]                  pc_to_ic,
  input  logic                             inst_get_ready,
  input  logic [XLEN-1:0]                  inst_from_ic,
  output logic                             inst_send_enable,
  output logic [XLEN-1:0]                  inst_to_issue,
  output logic [XLEN-1:0]                  pc_to_issue,
  output logic                             pred_taken_to_issue,
  input  logic                             issue_stall,
  input  logic                             jump_flag,
  input  logic [XLEN-1:0]                  target_pc,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0] queue_count
);

  localparam int EW = entry_width(XLEN);
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);

  fetch_state_t    state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt;
  logic [XLEN-1:0] pc_to_ic_nxt;
  logic            pc_send_nxt;
  logic            inst_send_nxt;
  logic [XLEN-1:0] inst_iss_nxt, pc_iss_nxt;
  logic            pred_iss_nxt;
  logic            push, pop, flush;
  logic [EW-1:0]   push_data, head;
  logic [XLEN-1:0] next_pc;
  logic            pred;

`ifdef IF_JAL_PREDICT_EN
  logic [XLEN-1:0] jal_off;
  assign jal_off = {{(XLEN-20){inst_from_ic[31]}}, inst_from_ic[19:12], inst_from_ic[20],
                    inst_from_ic[30:21], 1'b0};
  assign pred    = (inst_from_ic[6:0] == OPCODE_JAL);
  assign next_pc = pred ? pc + jal_off : pc + XLEN'(4);
`else
  assign pred    = LOW;
  assign next_pc = pc + XLEN'(4);
`endif

  assign push_data = {pred, pc, inst_from_ic};

  fetch_queue_fifo #(
    .WIDTH (EW),
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (flush),
    .head_data (head),
    .count     (queue_count)
  );

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    pc_to_ic_nxt  = pc_to_ic;
    pc_send_nxt   = pc_send_enable;
    inst_send_nxt = LOW;
    inst_iss_nxt  = inst_to_issue;
    pc_iss_nxt    = pc_to_issue;
    pred_iss_nxt  = pred_taken_to_issue;
    push          = LOW;
    pop           = LOW;
    flush         = LOW;

    if (!rdy) begin
      pc_send_nxt = LOW;
    end else if (jump_flag) begin
      pc_nxt      = target_pc;
      state_nxt   = IDLE;
      flush       = HIGH;
      pc_send_nxt = LOW;
    end else begin
      case (state)
        IDLE: begin
          // Occupancy before this cycle's pop, so a full queue never accepts a push.
          if (queue_count < DEPTH_C) begin
            pc_to_ic_nxt = pc;
            pc_send_nxt  = HIGH;
            state_nxt    = WAIT;
          end else begin
            pc_send_nxt = LOW;
          end
        end
        WAIT: begin
          if (inst_get_ready) begin
            push        = HIGH;
            pc_nxt      = next_pc;
            pc_send_nxt = LOW;
            state_nxt   = IDLE;
          end else begin
            pc_send_nxt = HIGH;
          end
        end
        default: state_nxt = IDLE;
      endcase

      if ((queue_count != '0) && !issue_stall) begin
        pop           = HIGH;
        inst_send_nxt = HIGH;
        inst_iss_nxt  = head[XLEN-1:0];
        pc_iss_nxt    = head[2*XLEN-1:XLEN];
        pred_iss_nxt  = head[EW-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= IDLE;
      pc                  <= RESET_PC;
      pc_to_ic            <= '0;
      pc_send_enable      <= LOW;
      inst_send_enable    <= LOW;
      inst_to_issue       <= '0;
      pc_to_issue         <= '0;
      pred_taken_to_issue <= LOW;
    end else begin
      state               <= state_nxt;
      pc                  <= pc_nxt;
      pc_to_ic            <= pc_to_ic_nxt;
      pc_send_enable      <= pc_send_nxt;
      inst_send_enable    <= inst_send_nxt;
      inst_to_issue       <= inst_iss_nxt;
      pc_to_issue         <= pc_iss_nxt;
      pred_taken_to_issue <= pred_iss_nxt;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: directed vector table, corner-case sequences, then random traffic vs a queue model.
module tb_inst_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        pc_send_enable;
  logic [31:0] pc_to_ic;
  logic        inst_get_ready;
  logic [31:0] inst_from_ic;
  logic        inst_send_enable;
  logic [31:0] inst_to_issue;
  logic [31:0] pc_to_issue;
  logic        pred_taken_to_issue;
  logic        issue_stall;
  logic        jump_flag;
  logic [31:0] target_pc;
  logic [2:0]  queue_count;

  inst_fetch_queue #(.XLEN(32), .QUEUE_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .rdy                 (rdy),
    .pc_send_enable      (pc_send_enable),
    .pc_to_ic            (pc_to_ic),
    .inst_get_ready      (inst_get_ready),
    .inst_from_ic        (inst_from_ic),
    .inst_send_enable    (inst_send_enable),
    .inst_to_issue       (inst_to_issue),
    .pc_to_issue         (pc_to_issue),
    .pred_taken_to_issue (pred_taken_to_issue),
    .issue_stall         (issue_stall),
    .jump_flag           (jump_flag),
    .target_pc           (target_pc),
    .queue_count         (queue_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic st, input logic j, input logic [31:0] tgt,
                     input logic rs, input logic [31:0] ins);
    rdy = r; issue_stall = st; jump_flag = j; target_pc = tgt;
    inst_get_ready = rs; inst_from_ic = ins;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rdy = 1'b1; issue_stall = 1'b0; jump_flag = 1'b0; target_pc = '0;
    inst_get_ready = 1'b0; inst_from_ic = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Architectural next PC: +4, or the JAL target when prediction is built in.
  function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] ins);
    int off;
`ifdef IF_JAL_PREDICT_EN
    if (ins[6:0] == 7'h6F) begin
      off = int'(ins[30:21]) * 2 + int'(ins[20]) * 2048 + int'(ins[19:12]) * 4096;
      if (ins[31]) off = off - (1 << 20);
      return p + off;
    end
`endif
    off = 4;
    return p + off;
  endfunction

  function automatic logic model_pred(input logic [31:0] ins);
`ifdef IF_JAL_PREDICT_EN
    return ins[6:0] == 7'h6F;
`else
    return 1'b0 & ins[0];
`endif
  endfunction

  typedef struct {
    logic        rdy;
    logic        resp;
    logic [31:0] inst;
    logic        e_pcse;
    logic [31:0] e_pc_ic;
    logic        e_ise;
    logic [31:0] e_pc_iss;
    int          e_cnt;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred;
  } ent_t;

  vec_t tbl[13];
  ent_t mq[$];

  initial begin
    logic [31:0] m_pc, ins, tgt, exp_next;
    logic        r, st, j, rs;
    int          hits, sz_before;
    ent_t        e;

    tbl[0]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h0,  1'b0, 32'h0, 0};
    tbl[1]  = '{1'b1, 1'b1, 32'h13, 1'b0, 32'h0,  1'b0, 32'h0, 1};
    tbl[2]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h4,  1'b1, 32'h0, 0};
    tbl[3]  = '{1'b1, 1'b1, 32'h13, 1'b0, 32'h4,  1'b0, 32'h0, 1};
    tbl[4]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h8,  1'b1, 32'h4, 0};
    tbl[5]  = '{1'b1, 1'b1, 32'h13, 1'b0, 32'h8,  1'b0, 32'h4, 1};
    tbl[6]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'hC,  1'b1, 32'h8, 0};
    tbl[7]  = '{1'b0, 1'b1, 32'h77, 1'b0, 32'hC,  1'b0, 32'h8, 0};
    tbl[8]  = '{1'b0, 1'b1, 32'h77, 1'b0, 32'hC,  1'b0, 32'h8, 0};
    tbl[9]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'hC,  1'b0, 32'h8, 0};
    tbl[10] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'hC,  1'b0, 32'h8, 0};
    tbl[11] = '{1'b1, 1'b1, 32'h13, 1'b0, 32'hC,  1'b0, 32'h8, 1};
    tbl[12] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h10, 1'b1, 32'hC, 0};

    // Reset state
    do_reset();
    chk("rst_pc_send_enable", pc_send_enable, 0);
    chk("rst_pc_to_ic", pc_to_ic, 0);
    chk("rst_inst_send_enable", inst_send_enable, 0);
    chk("rst_pc_to_issue", pc_to_issue, 0);
    chk("rst_pred", pred_taken_to_issue, 0);
    chk("rst_count", queue_count, 0);

    // Streaming fetch/issue and rdy pause during WAIT
    for (int i = 0; i < 13; i++) begin
      cyc(tbl[i].rdy, 1'b0, 1'b0, 32'h0, tbl[i].resp, tbl[i].inst);
      chk($sformatf("vec%0d_pc_send_enable", i), pc_send_enable, tbl[i].e_pcse);
      chk($sformatf("vec%0d_pc_to_ic", i), pc_to_ic, tbl[i].e_pc_ic);
      chk($sformatf("vec%0d_inst_send_enable", i), inst_send_enable, tbl[i].e_ise);
      chk($sformatf("vec%0d_pc_to_issue", i), pc_to_issue, tbl[i].e_pc_iss);
      chk($sformatf("vec%0d_count", i), queue_count, tbl[i].e_cnt);
      if (tbl[i].e_ise) chk($sformatf("vec%0d_inst_to_issue", i), inst_to_issue, 32'h13);
    end

    // Fill under stall, then drain back-to-back
    do_reset();
    hits = 0;
    for (int i = 0; i < 12; i++) begin
      rs = pc_send_enable;
      if (rs) hits++;
      cyc(1'b1, 1'b1, 1'b0, 32'h0, rs, 32'h13);
    end
    chk("fill_hits", hits, DEPTH);
    chk("fill_count", queue_count, DEPTH);
    chk("fill_pc_send_enable", pc_send_enable, 0);
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      chk($sformatf("drain%0d_inst_send_enable", i), inst_send_enable, 1);
      chk($sformatf("drain%0d_pc_to_issue", i), pc_to_issue, 32'(4 * i));
    end
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("drain_done_inst_send_enable", inst_send_enable, 0);

    // Jump coinciding with a hit while three entries are queued
    for (int i = 0; i < 20 && !(queue_count == 3 && pc_send_enable); i++)
      cyc(1'b1, 1'b1, 1'b0, 32'h0, pc_send_enable, 32'h13);
    chk("jump_setup_count", queue_count, 3);
    cyc(1'b1, 1'b0, 1'b1, 32'h1000, 1'b1, 32'h13);
    chk("jump_count", queue_count, 0);
    chk("jump_inst_send_enable", inst_send_enable, 0);
    chk("jump_pc_send_enable", pc_send_enable, 0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("jump_refetch_en", pc_send_enable, 1);
    chk("jump_refetch_pc", pc_to_ic, 32'h1000);
    chk("jump_no_stale_issue", inst_send_enable, 0);

    // PC wrap-around
    cyc(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("wrap_first_pc", pc_to_ic, 32'hFFFF_FFFC);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h13);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("wrap_second_en", pc_send_enable, 1);
    chk("wrap_second_pc", pc_to_ic, 32'h0);
    chk("wrap_issue_pc", pc_to_issue, 32'hFFFF_FFFC);

    // JAL at 0x20
    cyc(1'b1, 1'b0, 1'b1, 32'h20, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("jal_fetch_pc", pc_to_ic, 32'h20);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0100_006F);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
`ifdef IF_JAL_PREDICT_EN
    chk("jal_next_pc", pc_to_ic, 32'h30);
    chk("jal_pred", pred_taken_to_issue, 1);
`else
    chk("jal_next_pc", pc_to_ic, 32'h24);
    chk("jal_pred", pred_taken_to_issue, 0);
`endif
    chk("jal_issue_en", inst_send_enable, 1);
    chk("jal_issue_pc", pc_to_issue, 32'h20);
    chk("jal_issue_inst", inst_to_issue, 32'h0100_006F);

    // Random traffic against the queue model
    do_reset();
    m_pc = 32'h0;
    mq.delete();
    for (int c = 0; c < 1500; c++) begin
      r  = ($urandom % 8) != 0;
      st = ($urandom % 3) == 0;
      j  = ($urandom % 40) == 0;
      tgt = $urandom;
      tgt[1:0] = 2'b00;
      if ($urandom % 4 == 0) tgt[31:8] = 24'hFFFFFF;
      ins = $urandom;
      if ($urandom % 4 == 0) ins[6:0] = 7'h6F;
      rs = r ? (pc_send_enable && ($urandom % 2 == 0)) : ($urandom % 2 == 0);
      sz_before = mq.size();
      cyc(r, st, j, tgt, rs, ins);

      if (!r) begin
        chk("rnd_pause_pc_send_enable", pc_send_enable, 0);
        chk("rnd_pause_inst_send_enable", inst_send_enable, 0);
      end else if (j) begin
        mq.delete();
        m_pc = tgt;
        chk("rnd_jump_inst_send_enable", inst_send_enable, 0);
      end else begin
        if (rs) begin
          e.pc = m_pc; e.inst = ins; e.pred = model_pred(ins);
          mq.push_back(e);
          exp_next = model_next(m_pc, ins);
          m_pc = exp_next;
        end
        chk("rnd_issue_fire", inst_send_enable, (sz_before > 0) && !st);
        if (inst_send_enable && mq.size() > 0) begin
          e = mq.pop_front();
          chk("rnd_issue_pc", pc_to_issue, e.pc);
          chk("rnd_issue_inst", inst_to_issue, e.inst);
          chk("rnd_issue_pred", pred_taken_to_issue, e.pred);
        end
      end
      chk("rnd_count", queue_count, mq.size());
      if (pc_send_enable) chk("rnd_pc_to_ic", pc_to_ic, m_pc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
